// File: rtl/clk_div_monitor.sv
// Period / high-time checker for a divide-by-EXP_PERIOD clock sampled as data in the clk domain.
// Define CLK_DIV_MONITOR_SYNC_EN to add a 2-flop synchronizer ahead of the edge detector.
module clk_div_monitor #(
  parameter int CW         = 4,
  parameter int EXP_PERIOD = 5,
  parameter int HIGH_MIN   = 2,
  parameter int HIGH_MAX   = 3,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 12,
  parameter int ECW        = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_enable,
  input  logic           i_div_clk,
  input  logic           i_clr_err,
  output logic [1:0]     o_state,
  output logic           o_lock,
  output logic [CW-1:0]  o_period,
  output logic [CW-1:0]  o_high,
  output logic           o_meas_valid,
  output logic           o_err,
  output logic           o_timeout,
  output logic [ECW-1:0] o_err_count
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0]  CNT_MAX = '1;
  localparam logic [ECW-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    CHECK  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_s0, r_s1;
  logic          w_div_in;
  logic          w_rise;
  logic [CW-1:0] r_per_cnt, r_hi_cnt;
  logic [GW-1:0] r_good_cnt, w_good_nxt, w_good_inc;
  logic          r_meas_pend;
  logic          w_good_period;
  logic          w_timeout_hit;
  logic          w_err;
  logic          w_timeout_evt;
  logic          w_measuring;

`ifdef CLK_DIV_MONITOR_SYNC_EN
  logic r_sync1, r_sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_div_clk;
      r_sync2 <= r_sync1;
    end
  end

  assign w_div_in = r_sync2;
`else
  assign w_div_in = i_div_clk;
`endif

  assign w_rise        = r_s0 & ~r_s1;
  assign w_measuring   = (r_state == CHECK) || (r_state == LOCKED);
  assign w_good_inc    = r_good_cnt + GW'(1);
  assign w_timeout_hit = !w_rise && (r_per_cnt == CW'(TIMEOUT));
  // The verdict uses the registered measurement, one cycle after the rise that captured it.
  assign w_good_period = (o_period == CW'(EXP_PERIOD)) &&
                         (o_high >= CW'(HIGH_MIN)) && (o_high <= CW'(HIGH_MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_good_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_good_nxt    = r_good_cnt;
    w_err         = 1'b0;
    w_timeout_evt = 1'b0;
    if (!i_enable) begin
      w_state_nxt = IDLE;
      w_good_nxt  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = ACQ;
          w_good_nxt  = '0;
        end
        ACQ: begin
          if (w_rise) begin
            w_state_nxt = CHECK;
            w_good_nxt  = '0;
          end
        end
        CHECK, LOCKED: begin
          if (r_meas_pend) begin
            if (w_good_period) begin
              if (r_state == CHECK) begin
                w_good_nxt = w_good_inc;
                if (w_good_inc == GW'(LOCK_CNT)) w_state_nxt = LOCKED;
              end
            end else begin
              w_state_nxt = CHECK;
              w_good_nxt  = '0;
              w_err       = 1'b1;
            end
          end else if (w_timeout_hit) begin
            w_state_nxt   = ACQ;
            w_good_nxt    = '0;
            w_err         = 1'b1;
            w_timeout_evt = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s0         <= 1'b0;
      r_s1         <= 1'b0;
      r_per_cnt    <= '0;
      r_hi_cnt     <= '0;
      r_meas_pend  <= 1'b0;
      o_period     <= '0;
      o_high       <= '0;
      o_meas_valid <= 1'b0;
      o_err        <= 1'b0;
      o_timeout    <= 1'b0;
      o_err_count  <= '0;
    end else begin
      r_s0         <= w_div_in;
      r_s1         <= r_s0;
      o_err        <= w_err;
      o_meas_valid <= i_enable && r_meas_pend;

      if (!i_enable || r_state == IDLE) begin
        r_per_cnt   <= '0;
        r_hi_cnt    <= '0;
        r_meas_pend <= 1'b0;
      end else begin
        r_meas_pend <= w_rise && w_measuring;
        if (w_rise) begin
          r_per_cnt <= CW'(1);
          r_hi_cnt  <= CW'(1);
          if (w_measuring) begin
            o_period <= r_per_cnt;
            o_high   <= r_hi_cnt;
          end
        end else begin
          if (r_per_cnt != CNT_MAX) r_per_cnt <= r_per_cnt + CW'(1);
          if (r_s0 && r_hi_cnt != CNT_MAX) r_hi_cnt <= r_hi_cnt + CW'(1);
        end
      end

      // A clear coinciding with a new error keeps that error visible.
      if (i_clr_err) begin
        o_err_count <= w_err ? ECW'(1) : '0;
        o_timeout   <= w_timeout_evt;
      end else begin
        if (w_err && o_err_count != ERR_MAX) o_err_count <= o_err_count + ECW'(1);
        if (w_timeout_evt) o_timeout <= 1'b1;
      end
    end
  end

  assign o_state = r_state;
  assign o_lock  = (r_state == LOCKED);

endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
- Downstream checker for the divide-by-5 clock generator; samples its divided-clock output in the source clk domain.
- Measures period and sampled high time of every divided-clock cycle and declares lock after consecutive in-spec periods.
- Flags out-of-spec periods and missing edges, and keeps a saturating error count for bring-up and BIST status registers.

Parameters:
CW, 4, width of period/high-time counters and outputs
EXP_PERIOD, 5, required period in clk cycles between divided-clock rising edges
HIGH_MIN, 2, minimum legal sampled high time (clk cycles)
HIGH_MAX, 3, maximum legal sampled high time (clk cycles)
LOCK_CNT, 4, consecutive good periods required to assert lock
TIMEOUT, 12, cycles without a rising edge before timeout (must be < 2^CW)
ECW, 8, error counter width

Ports:
clk  input  1  system clock (same clock that drives the divider)
reset  input  1  synchronous, active-high reset
i_enable  input  1  monitor enable; low forces IDLE
i_div_clk  input  1  divided clock under test, treated as data
i_clr_err  input  1  one-cycle pulse: clears o_err_count and o_timeout
o_state  output  2  FSM state: 0 IDLE, 1 ACQ, 2 CHECK, 3 LOCKED
o_lock  output  1  high while in LOCKED
o_period  output  CW  last measured period
o_high  output  CW  last measured high time
o_meas_valid  output  1  one-cycle pulse when o_period/o_high update
o_err  output  1  one-cycle pulse on bad period or timeout
o_timeout  output  1  sticky timeout flag
o_err_count  output  ECW  saturating count of o_err pulses

Behaviour:
- One clock, synchronous active-high reset. All outputs reset to 0; state IDLE.
- Sampling: i_div_clk registered into s0, then s1; rise = s0 & ~s1. No other edge source.
- per_cnt: counts clk cycles since last rise; set to 1 on the cycle after a rise; saturates at 2^CW-1.
- hi_cnt: counts cycles with s0=1 since last rise, including the rise cycle.
- On rise, in CHECK/LOCKED: o_period <= per_cnt, o_high <= hi_cnt, o_meas_valid pulses next cycle. Clean div-by-5 input gives o_period=5.
- Latency: o_meas_valid asserts 3 clk edges after the edge that first samples i_div_clk high.
- Good period: o_period == EXP_PERIOD and HIGH_MIN <= o_high <= HIGH_MAX.
- FSM transitions:
  - IDLE: counters held at 0; goes to ACQ when i_enable=1.
  - ACQ: waits for the first rise. No measurement is made, because the first period is partial. On rise goes to CHECK with good_cnt=0.
  - CHECK: good period increments good_cnt; when good_cnt reaches LOCK_CNT, goes to LOCKED in the same cycle as o_meas_valid. Bad period clears good_cnt, pulses o_err, stays in CHECK.
  - LOCKED: good period stays in LOCKED. Bad period goes to CHECK with good_cnt=0; o_lock drops and o_err pulses in the same cycle.
- Timeout: in CHECK/LOCKED, if per_cnt reaches TIMEOUT with no rise, go to ACQ, set o_timeout, pulse o_err, drop o_lock. No measurement update.
- i_enable low in any state: IDLE on next edge, o_lock=0, good_cnt/per_cnt/hi_cnt cleared. o_err_count, o_timeout, o_period and o_high are retained.
- o_err_count increments on each o_err pulse and saturates at 2^ECW-1.
- i_clr_err and o_err in the same cycle: count becomes 1 and o_timeout reflects the current event.
- Reset mid-measurement aborts immediately with no o_err pulse.

Optional Feature:
- Macro: CLK_DIV_MONITOR_SYNC_EN.
- Defined: i_div_clk passes through a 2-flop synchronizer ahead of s0, so the monitor is safe for asynchronous sources. Latency becomes 5 edges; measurement values are unchanged.
- Undefined: a single s0 register only, for same-clock sources. Latency is 3 edges.

Test Plan:
- Clean div-by-5 waveform (high 3, low 2) after enable -> ACQ, CHECK, then LOCKED at the 4th o_meas_valid; o_period=5, o_high=3, o_err=0, o_err_count=0.
- While locked, inject one period of 6 -> o_err pulse, o_lock=0, state CHECK, o_err_count=1; relock after 4 further good periods.
- Period 5 with high time 4 -> bad period, o_err pulse, o_high=4, good_cnt restarts at 0.
- Hold i_div_clk low while LOCKED -> 12 cycles after the last rise: o_timeout=1, o_err pulse, state ACQ; i_clr_err then clears o_timeout and o_err_count to 0.
- Force 300 bad periods with ECW=8 -> o_err_count saturates at 255. Pulse i_clr_err in the same cycle as an error -> o_err_count=1.
- Assert reset or drop i_enable mid-period -> all outputs 0 (reset) or state IDLE with counts retained (enable); no spurious o_err.
